// File: rtl/cla_wide_seq_if.sv
`default_nettype none
// ============================================================================
// cla_wide_seq_if : request/result bundle for the chunked CLA sequencer
// Revision: 1.0
// ============================================================================
interface cla_wide_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output start, a, b, sub, cin,
      input  busy, done, sum, cout, ovf, zero
   );

   modport slave (
      input  start, a, b, sub, cin,
      output busy, done, sum, cout, ovf, zero
   );
endinterface
`default_nettype wire

// File: rtl/cla_wide_seq.sv
`default_nettype none
// ============================================================================
// cla_wide_seq : WIDTH-bit add/sub through one CHUNK-bit CLA slice, LSB first
// Revision: 1.0
// ============================================================================
module cla_wide_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input wire logic          clk,
   input wire logic          rst,
   cla_wide_seq_if.slave     bus
);

   localparam int N    = WIDTH / CHUNK;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;
   localparam int NG   = CHUNK / 4;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             c_q, c_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             done_q, done_d;

   logic [CHUNK-1:0] w_a_chunk, w_b_chunk;
   logic [CHUNK-1:0] w_p, w_g, w_s;
   logic             w_cout, w_cmsb_in, w_carry;
   logic [3:0]       w_p4, w_g4, w_c4;
   logic             w_bp, w_bg;

   assign w_a_chunk = a_q[idx_q*CHUNK +: CHUNK];
   assign w_b_chunk = b_q[idx_q*CHUNK +: CHUNK];
   assign w_p       = w_a_chunk ^ w_b_chunk;
   assign w_g       = w_a_chunk & w_b_chunk;

   // Lookahead inside each 4-bit group; block P/G carries hop between groups.
   always_comb begin
      w_s       = '0;
      w_cmsb_in = 1'b0;
      w_carry   = c_q;
      w_p4      = '0;
      w_g4      = '0;
      w_c4      = '0;
      w_bp      = 1'b0;
      w_bg      = 1'b0;
      for (int gi = 0; gi < NG; gi++) begin
         w_p4    = w_p[gi*4 +: 4];
         w_g4    = w_g[gi*4 +: 4];
         w_c4[0] = w_carry;
         w_c4[1] = w_g4[0] | (w_p4[0] & w_carry);
         w_c4[2] = w_g4[1] | (w_p4[1] & w_g4[0]) | (w_p4[1] & w_p4[0] & w_carry);
         w_c4[3] = w_g4[2] | (w_p4[2] & w_g4[1]) | (w_p4[2] & w_p4[1] & w_g4[0])
                 | (w_p4[2] & w_p4[1] & w_p4[0] & w_carry);
         w_bp    = &w_p4;
         w_bg    = w_g4[3] | (w_p4[3] & w_g4[2]) | (w_p4[3] & w_p4[2] & w_g4[1])
                 | (w_p4[3] & w_p4[2] & w_p4[1] & w_g4[0]);
         w_s[gi*4 +: 4] = w_p4 ^ w_c4;
         if (gi == NG - 1) begin
            w_cmsb_in = w_c4[3];
         end
         w_carry = w_bg | (w_bp & w_carry);
      end
      w_cout = w_carry;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               // Subtract as A + ~B + 1; cin then acts as an extra borrow.
               b_d     = bus.sub ? ~bus.b : bus.b;
               c_d     = bus.cin ^ bus.sub;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
               zero_d  = 1'b0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_d[idx_q*CHUNK +: CHUNK] = w_s;
            c_d   = w_cout;
            idx_d = idx_q + IDXW'(1);
            if (idx_q == LAST_IDX) begin
               cout_d  = w_cout;
               ovf_d   = w_cmsb_in ^ w_cout;
               zero_d  = (sum_d == '0);
               done_d  = 1'b1;
               idx_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = (state_q == S_RUN);
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;
   assign bus.zero = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_wide_seq.sv
`default_nettype none
// ============================================================================
// tb_cla_wide_seq : directed vectors for cla_wide_seq (WIDTH=32, CHUNK=8)
// Revision: 1.0
// ============================================================================
module tb_cla_wide_seq;

   localparam int WIDTH   = 32;
   localparam int CHUNK   = 8;
   localparam int LATENCY = WIDTH / CHUNK;
   localparam int TIMEOUT = 20;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   cla_wide_seq_if #(.WIDTH(WIDTH)) bus ();

   cla_wide_seq #(
      .WIDTH(WIDTH),
      .CHUNK(CHUNK)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < TIMEOUT) begin
         tick();
         cyc++;
      end
   endtask

   // Accept one op, check latency and the full result, then check hold.
   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic ci, input logic [31:0] es,
                        input logic ec, input logic eo, input logic ez);
      int cyc;
      bus.a     = a;
      bus.b     = b;
      bus.sub   = s;
      bus.cin   = ci;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      bus.sub   = ~s;
      bus.cin   = ~ci;
      chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
      chk({tag, ".clr"}, 64'({bus.sum, bus.cout, bus.ovf, bus.zero}), 64'd0);
      wait_done(cyc);
      chk({tag, ".lat"}, 64'(cyc), 64'(LATENCY));
      chk({tag, ".sum"}, 64'(bus.sum), 64'(es));
      chk({tag, ".flags"}, 64'({bus.cout, bus.ovf, bus.zero}), 64'({ec, eo, ez}));
      chk({tag, ".busy0"}, 64'(bus.busy), 64'd0);
      tick();
      chk({tag, ".done1cyc"}, 64'(bus.done), 64'd0);
      chk({tag, ".hold"}, 64'(bus.sum), 64'(es));
   endtask

   initial begin
      int cyc;
      int busy_seen;
      int done_seen;
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.sub   = 1'b0;
      bus.cin   = 1'b0;
      repeat (3) tick();
      chk("reset.outs", 64'({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf, bus.zero}), 64'd0);
      rst = 1'b0;

      busy_seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.busy === 1'b1 || bus.done === 1'b1) busy_seen++;
      end
      chk("idle.nobusy", 64'(busy_seen), 64'd0);

      do_op("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      do_op("ovf_add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      do_op("ovf_sub", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
      do_op("borrow", 32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      do_op("sub_eq", 32'd7, 32'd7, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      do_op("sub_cin", 32'd10, 32'd3, 1'b1, 1'b1, 32'd6, 1'b1, 1'b0, 1'b0);
      do_op("add_cin", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, 1'b0, 1'b0);
      do_op("neg_add", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);

      // Start during busy is ignored, then back-to-back accept in the done cycle.
      bus.a     = 32'd1;
      bus.b     = 32'd2;
      bus.sub   = 1'b0;
      bus.cin   = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      bus.a     = 32'd100;
      bus.b     = 32'd100;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done(cyc);
      chk("ignore.lat", 64'(cyc), 64'd1);
      chk("ignore.sum", 64'(bus.sum), 64'd3);
      bus.a     = 32'd10;
      bus.b     = 32'd20;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("b2b.busy", 64'(bus.busy), 64'd1);
      chk("b2b.clr", 64'(bus.sum), 64'd0);
      wait_done(cyc);
      chk("b2b.lat", 64'(cyc), 64'(LATENCY));
      chk("b2b.sum", 64'(bus.sum), 64'd30);

      // Reset while the slice is on chunk 2.
      tick();
      bus.a     = 32'h1234_5678;
      bus.b     = 32'h1111_1111;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst.outs", 64'({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf, bus.zero}), 64'd0);
      done_seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
      end
      chk("midrst.nodone", 64'(done_seen), 64'd0);
      do_op("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
